// File: rtl/myproject_mac_pipe.sv
// Pipelined multiply / multiply-accumulate unit with per-operand signedness, clock enable,
// valid/first/last sideband tracking and an optional wrapping accumulator with sticky overflow.
module myproject_mac_pipe #(
  parameter int ID          = 1,
  parameter int DIN0_WIDTH  = 15,
  parameter int DIN1_WIDTH  = 16,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 1,
  parameter int NUM_STAGE   = 3,
  parameter int ACC_MODE    = 0,
  parameter int ACC_WIDTH   = 40,
  parameter int DOUT_WIDTH  = 31
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  in_valid,
  input  logic                  in_first,
  input  logic                  in_last,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  out_valid,
  output logic                  ovf
);

  localparam int PW  = DIN0_WIDTH + DIN1_WIDTH + 2;
  localparam int TOP = NUM_STAGE - 1;

  logic signed [DIN0_WIDTH:0] a_ext;
  logic signed [DIN1_WIDTH:0] b_ext;
  logic signed [PW-1:0]       prod;

  // One extra bit per operand lets signed and unsigned inputs share one signed multiplier.
  assign a_ext = {(DIN0_SIGNED != 0) & din0[DIN0_WIDTH-1], din0};
  assign b_ext = {(DIN1_SIGNED != 0) & din1[DIN1_WIDTH-1], din1};
  assign prod  = PW'(a_ext) * PW'(b_ext);

  logic [NUM_STAGE-1:0][PW-1:0] p_q;
  logic [NUM_STAGE:0][PW-1:0]   p_ext;
  logic [NUM_STAGE-1:0]         v_q, f_q, l_q;
  logic [NUM_STAGE:0]           v_ext, f_ext, l_ext;

  // Index i of the *_ext vectors is the value entering stage i; index 0 is the raw input.
  assign p_ext = {p_q, prod};
  assign v_ext = {v_q, in_valid};
  assign f_ext = {f_q, in_first};
  assign l_ext = {l_q, in_last};

  logic signed [ACC_WIDTH-1:0] acc_q, term, sum, acc_next;
  logic                        add_ovf, ovf_q;

  // NOTE: every variable gets a value on every path through this block, so no latch is inferred.
  always_comb begin
    term     = ACC_WIDTH'($signed(p_q[TOP]));
    sum      = acc_q + term;
    add_ovf  = (acc_q[ACC_WIDTH-1] == term[ACC_WIDTH-1]) &&
               (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    acc_next = f_q[TOP] ? term : sum;
  end

  // NOTE: state is updated with non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      v_q       <= '0;
      f_q       <= '0;
      l_q       <= '0;
      p_q       <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      dout      <= '0;
      out_valid <= 1'b0;
    end else if (ce) begin
      v_q <= v_ext[TOP:0];
      f_q <= f_ext[TOP:0];
      l_q <= l_ext[TOP:0];
      p_q <= p_ext[TOP:0];
      if (ACC_MODE == 0) begin
        // The output register doubles as the last product stage and holds across bubbles.
        out_valid <= v_ext[TOP];
        if (v_ext[TOP]) dout <= DOUT_WIDTH'($signed(p_ext[TOP]));
      end else begin
        out_valid <= v_q[TOP] && l_q[TOP];
        if (v_q[TOP]) begin
          acc_q <= acc_next;
          ovf_q <= f_q[TOP] ? 1'b0 : (ovf_q || add_ovf);
          if (l_q[TOP]) dout <= DOUT_WIDTH'(acc_next);
        end
      end
    end
  end

  assign ovf = (ACC_MODE != 0) && ovf_q;

endmodule
